// File: rtl/uart_memload_if.sv
// Loader bus: UART input line plus the memory write port and sticky status flags.
interface uart_memload_if;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  logic              RX;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              done;
  logic              err;

  modport master (input RX, output wr_en, wr_addr, wr_data, done, err);
  modport slave  (output RX, input wr_en, wr_addr, wr_data, done, err);
endinterface

// File: rtl/uart_memload.sv
// UART 8N1 receiver feeding an ASCII-hex line parser; each "XXXXXXXX[CR]LF" line
// becomes one 32-bit write into a 1024-word memory port.
module uart_memload #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic           CLK,
  input  logic           nrst,
  uart_memload_if.master bus
);
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF   = CLKS_PER_BIT / 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = 10'h3FF;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  typedef enum logic [1:0] {P_COLLECT, P_SKIP, P_DONE} p_state_t;

  // ---------------- RX front end ----------------
  logic             rx_meta, rx_sync;
  rx_state_t        rx_state, rx_next;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_shift;
  logic             byte_valid;
  logic             bit_tick_c, half_tick_c, sample_c, byte_ok_c, frame_err_c, cnt_clr_c;

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= bus.RX;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (!rx_sync) rx_next = RX_START;
      RX_START: if (half_tick_c) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_tick_c && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (bit_tick_c) rx_next = rx_sync ? RX_IDLE : RX_WAIT;
      RX_WAIT:  if (rx_sync) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    bit_tick_c  = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));
    half_tick_c = (rx_state == RX_START) && (bit_cnt == CNT_W'(HALF));
    sample_c    = (rx_state == RX_DATA) && bit_tick_c;
    byte_ok_c   = (rx_state == RX_STOP) && bit_tick_c && rx_sync;
    frame_err_c = (rx_state == RX_STOP) && bit_tick_c && !rx_sync;
    cnt_clr_c   = half_tick_c || bit_tick_c ||
                  (rx_state == RX_IDLE) || (rx_state == RX_WAIT);
  end

  // Bit timing restarts at the start-bit midpoint so data samples land mid-bit.
  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      bit_cnt    <= '0;
      bit_idx    <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
    end else begin
      bit_cnt    <= cnt_clr_c ? '0 : bit_cnt + CNT_W'(1);
      byte_valid <= byte_ok_c;
      if (rx_state == RX_IDLE) bit_idx <= '0;
      else if (sample_c)       bit_idx <= bit_idx + 3'd1;
      if (sample_c) rx_shift <= {rx_sync, rx_shift[7:1]};
    end
  end

  // ---------------- line parser ----------------
  p_state_t          p_state, p_next;
  logic [3:0]        dig_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              is_hex, is_cr, is_lf;
  logic [3:0]        nib;
  logic              write_c, fmt_err_c, shift_en_c, dig_clr_c;

  always_comb begin
    is_hex = 1'b0;
    nib    = 4'd0;
    is_cr  = (rx_shift == 8'h0D);
    is_lf  = (rx_shift == 8'h0A);
    if (rx_shift >= 8'h30 && rx_shift <= 8'h39) begin
      is_hex = 1'b1;
      nib    = rx_shift[3:0];
    end else if ((rx_shift >= 8'h41 && rx_shift <= 8'h46) ||
                 (rx_shift >= 8'h61 && rx_shift <= 8'h66)) begin
      is_hex = 1'b1;
      nib    = rx_shift[3:0] + 4'd9;
    end
  end

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) p_state <= P_COLLECT;
    else       p_state <= p_next;
  end

  always_comb begin
    p_next = p_state;
    if (byte_valid) begin
      case (p_state)
        P_COLLECT: begin
          if (is_hex && dig_cnt == 4'd8)                 p_next = P_SKIP;
          else if (!is_hex && !is_cr && !is_lf)          p_next = P_SKIP;
          else if (is_lf && dig_cnt == 4'd8 && bus.wr_addr == LAST_ADDR) p_next = P_DONE;
        end
        P_SKIP:  if (is_lf) p_next = P_COLLECT;
        P_DONE:  p_next = P_DONE;
        default: p_next = P_COLLECT;
      endcase
    end
  end

  always_comb begin
    write_c    = 1'b0;
    fmt_err_c  = 1'b0;
    shift_en_c = 1'b0;
    dig_clr_c  = 1'b0;
    if (byte_valid && p_state == P_COLLECT) begin
      write_c    = is_lf && dig_cnt == 4'd8;
      shift_en_c = is_hex && dig_cnt != 4'd8;
      dig_clr_c  = is_lf;
      fmt_err_c  = (is_hex && dig_cnt == 4'd8) ||
                   (is_lf && dig_cnt != 4'd0 && dig_cnt != 4'd8) ||
                   (!is_hex && !is_cr && !is_lf);
    end else if (byte_valid && p_state == P_SKIP) begin
      dig_clr_c = is_lf;
    end
  end

  // The address register doubles as the write pointer; it saturates at the last word.
  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      dig_cnt     <= '0;
      shift_reg   <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.done    <= 1'b0;
      bus.err     <= 1'b0;
    end else begin
      bus.wr_en <= write_c;
      if (write_c) bus.wr_data <= shift_reg;
      if (dig_clr_c)       dig_cnt <= '0;
      else if (shift_en_c) dig_cnt <= dig_cnt + 4'd1;
      if (shift_en_c) shift_reg <= {shift_reg[DATA_W-5:0], nib};
      if (bus.wr_en && bus.wr_addr != LAST_ADDR) bus.wr_addr <= bus.wr_addr + ADDR_W'(1);
      if (bus.wr_en && bus.wr_addr == LAST_ADDR) bus.done <= 1'b1;
      if (fmt_err_c || frame_err_c) bus.err <= 1'b1;
    end
  end
endmodule

// File: doc/uart_memload.md
# uart_memload

Serial loader that receives ASCII-hex text over a UART RX line and writes one 32-bit word per text line into a 1024-word memory port. It accepts exactly the line format produced by the data-memory dump block: 8 hex digits, MSB nibble first, then CR LF. The loader sits beside the core's memory and lets a host preload memory contents over the USB-UART bridge before the core is released from reset.

## Interface
- CLKS_PER_BIT, default 868: clock cycles per UART bit (100 MHz / 115200 baud); legal range 4..65535.
- CLK  input  1  system clock; all logic on rising edge.
- nrst  input  1  reset; asynchronous, active-low.
- RX  input  1  UART serial input, 8N1, idle high; asynchronous to CLK.
- wr_en  output  1  one-cycle memory write strobe.
- wr_addr  output  10  word address for the write; valid while wr_en=1.
- wr_data  output  32  word to write; valid while wr_en=1.
- done  output  1  sticky; high once word 0x3FF has been written.
- err  output  1  sticky; high after any framing or format error since reset.

## Operation
- RX front end: 2-flop synchronizer on RX (reset value 1). Bit counter counts 0..CLKS_PER_BIT-1.
- RX FSM states:
  - IDLE: wait for synchronized RX=0.
  - START: at CLKS_PER_BIT/2 (integer division), RX must still be 0, else glitch -> IDLE, no error.
  - DATA: sample 8 bits at full CLKS_PER_BIT intervals from the start-bit midpoint, LSB first.
  - STOP: sample at next midpoint. 1 -> emit internal byte_valid pulse with the byte, go IDLE. 0 -> framing error: set err, drop byte, wait for RX=1, then IDLE.
- Parser FSM states: COLLECT, SKIP, DONE.
- COLLECT, per received byte:
  - Hex digit '0'-'9', 'A'-'F' or 'a'-'f', with digit count < 8: shift_reg <= {shift_reg[27:0], nibble}, count++.
  - CR (0x0D): ignored.
  - LF (0x0A) with count=8: write pulse, clear count.
  - LF with count=0: empty line, ignored, no error.
  - LF with count 1..7: set err, clear count, no write.
  - Any other byte, or a 9th hex digit: set err, go SKIP.
- SKIP: discard bytes until LF, then clear count and return to COLLECT. The LF itself causes no write.
- Write: wr_data <= shift_reg, wr_en=1 for one cycle, wr_addr = current pointer. The pointer starts at 0 and increments by 1 after each write.
- After the write at 0x3FF: done<=1 and parser enters DONE. In DONE all further bytes are ignored (the RX FSM keeps running and framing errors still set err). The pointer never wraps; only reset leaves DONE.
- err and done are cleared only by nrst.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, done=0, err=0. RX FSM in IDLE, parser in COLLECT, count=0, shift_reg=0.
- Reset asserted mid-byte or mid-line aborts immediately. The partial word is lost and the next line after release is written to address 0.
- byte_valid occurs 1 cycle after the stop-bit sample. Parser consumes the byte in that same cycle.
- wr_en is registered and asserts the cycle after byte_valid of the terminating LF.
- wr_addr is updated to pointer+1 the cycle after wr_en. For the final word it stays at 0x3FF.
- done rises in the same cycle wr_en drops after the 0x3FF write.
- err rises the cycle after the offending byte_valid or failed stop sample.
- Minimum spacing between wr_en pulses equals the duration of 9 or 10 bytes (one full line). There is no back-pressure; the memory must accept a write every cycle wr_en=1.
- A start edge arriving in the same cycle STOP completes is detected on the next cycle. The bench must not send stop bits shorter than 1 bit time.

## Test plan
- CLKS_PER_BIT=16. Send "ADE1B055\r\n" then "0000002a\n" -> wr_en at addr 0 with data 0xADE1B055, then at addr 1 with data 0x0000002A. err=0, done=0.
- Send "12G45678\r\n" then "CAFEF00D\r\n" -> no write for the first line and err=1. Second line writes 0xCAFEF00D to addr 0.
- Send "123\r\n", then "123456789\r\n", then an empty "\r\n" -> no writes. err=1 after the first line. Address stays 0.
- Byte with stop bit forced 0 inside an otherwise valid line -> err=1. That byte is dropped; the line then completes with 7 digits -> no write.
- Send 1024 valid lines with data=address -> the last write is addr 0x3FF, data 0x3FF, and done=1 one cycle later. A further 1025th line produces no wr_en.
- Assert nrst after 4 digits of a line, release, send "DEADBEEF\r\n" -> all outputs 0 during reset, then a single write of 0xDEADBEEF at addr 0.
